// File: rtl/imem_fetch_arbiter_pkg.sv
// Shared types for the instruction-memory fetch arbiter: sequencer states,
// grant identities and the round-robin tie-break helper.
package imem_fetch_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_F0,
      ST_F1,
      ST_F2,
      ST_WR,
      ST_ACK
   } state_e;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_LD  = 1'b1
   } grant_e;

   // On a tie the requester that was not served last wins.
   function automatic grant_e rr_pick(input grant_e last);
      return (last == GNT_CPU) ? GNT_LD : GNT_CPU;
   endfunction

endpackage

// File: rtl/imem_fetch_arbiter.sv
// Shares the single-port byte-wide instruction SRAM between the CPU fetch unit
// (16-bit instructions built from two byte reads) and the boot/debug loader.
module imem_fetch_arbiter
   import imem_fetch_arbiter_pkg::*;
#(
   parameter int unsigned MEM_DATA_WIDTH = 8,
   parameter int unsigned MEM_ADDR_WIDTH = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ld_mode,
   input  logic                          cpu_req,
   input  logic [MEM_ADDR_WIDTH-2:0]     cpu_addr,
   output logic                          cpu_ack,
   output logic [2*MEM_DATA_WIDTH-1:0]   cpu_instr,
   input  logic                          ld_req,
   input  logic [MEM_ADDR_WIDTH-1:0]     ld_addr,
   input  logic [MEM_DATA_WIDTH-1:0]     ld_data,
   output logic                          ld_ack,
   output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
   output logic                          mem_we,
   output logic [MEM_DATA_WIDTH-1:0]     mem_wdata,
   input  logic [MEM_DATA_WIDTH-1:0]     mem_rdata
);

   state_e                        state_q, state_d;
   grant_e                        last_grant_q, last_grant_d;
   logic [MEM_ADDR_WIDTH-2:0]     word_addr_q, word_addr_d;
   logic [MEM_DATA_WIDTH-1:0]     hi_q, hi_d;
   logic                          cpu_ack_q, cpu_ack_d;
   logic                          ld_ack_q, ld_ack_d;
   logic [2*MEM_DATA_WIDTH-1:0]   cpu_instr_q, cpu_instr_d;
   logic [MEM_ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
   logic                          mem_we_q, mem_we_d;
   logic [MEM_DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
   logic                          gnt_cpu, gnt_ld;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GNT_CPU;
         word_addr_q  <= '0;
         hi_q         <= '0;
         cpu_ack_q    <= 1'b0;
         ld_ack_q     <= 1'b0;
         cpu_instr_q  <= '0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         word_addr_q  <= word_addr_d;
         hi_q         <= hi_d;
         cpu_ack_q    <= cpu_ack_d;
         ld_ack_q     <= ld_ack_d;
         cpu_instr_q  <= cpu_instr_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt_cpu      = 1'b0;
      gnt_ld       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ld_mode) begin
               gnt_ld = ld_req;
            end else if (cpu_req && ld_req) begin
               gnt_ld  = (rr_pick(last_grant_q) == GNT_LD);
               gnt_cpu = !gnt_ld;
            end else begin
               gnt_cpu = cpu_req;
               gnt_ld  = ld_req;
            end
            if (gnt_cpu) begin
               state_d      = ST_F0;
               last_grant_d = GNT_CPU;
            end else if (gnt_ld) begin
               state_d      = ST_WR;
               last_grant_d = GNT_LD;
            end
         end
         ST_F0:   state_d = ST_F1;
         ST_F1:   state_d = ST_F2;
         ST_F2:   state_d = ST_ACK;
         ST_WR:   state_d = ST_ACK;
         // Requester still holds req during the ack cycle, so never grant here.
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      word_addr_d = word_addr_q;
      hi_d        = hi_q;
      cpu_instr_d = cpu_instr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_ack_d   = 1'b0;
      ld_ack_d    = 1'b0;
      mem_we_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_cpu) begin
               word_addr_d = cpu_addr;
               mem_addr_d  = {cpu_addr, 1'b0};
            end else if (gnt_ld) begin
               mem_addr_d  = ld_addr;
               mem_wdata_d = ld_data;
               mem_we_d    = 1'b1;
            end
         end
         ST_F0: mem_addr_d = {word_addr_q, 1'b1};
         // Memory output is registered: byte 2a arrives in F1, byte 2a+1 in F2.
         ST_F1: hi_d = mem_rdata;
         ST_F2: begin
            cpu_instr_d = {hi_q, mem_rdata};
            cpu_ack_d   = 1'b1;
         end
         ST_WR: ld_ack_d = 1'b1;
         default: ;
      endcase
   end

   assign cpu_ack   = cpu_ack_q;
   assign cpu_instr = cpu_instr_q;
   assign ld_ack    = ld_ack_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;

endmodule
